// File: rtl/uart_seq_pkg.sv
// Shared state encoding and default constants for the UART frame sequencer.
package uart_seq_pkg;

   localparam int SEQ_DATA_W_DEF     = 8;
   localparam int SEQ_GAP_CYCLES_DEF = 52084;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   // Counter width able to hold max_val; never below one bit so a zero gap still elaborates.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sequencer_gap_timer.sv
// Loadable down-counter that times the idle gap between two bytes of a frame.
module sequencer_gap_timer
   import uart_seq_pkg::*;
#(
   parameter int CNT_W = cnt_width(SEQ_GAP_CYCLES_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = value_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The last gap cycle is the one holding 1, so the next byte is offered right after it.
   assign expire_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/uart_frame_sequencer.sv
// Latches a command frame and feeds it byte by byte to the UART TX with a programmable gap.
// Define SEQ_CHECKSUM_EN to append a modulo-2^DATA_W sum trailer byte to every frame.
module uart_frame_sequencer
   import uart_seq_pkg::*;
#(
   parameter int DATA_W     = SEQ_DATA_W_DEF,
   parameter int MAX_BYTES  = 16,
   parameter int GAP_CYCLES = SEQ_GAP_CYCLES_DEF,
   parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [LEN_W-1:0]            len,
   input  logic [MAX_BYTES*DATA_W-1:0] frame,
   input  logic                        abort,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  dbg_state_o
);

   localparam int CNT_W   = cnt_width(GAP_CYCLES);
   localparam int FRAME_W = MAX_BYTES * DATA_W;

   seq_state_t          state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    len_clamped;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [DATA_W-1:0]   byte_sel;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                last_byte;
   logic                handshake;
   logic                tmr_load, tmr_en, tmr_clr, tmr_expire;
`ifdef SEQ_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_q, csum_d;
`endif

   // A byte transfers on an edge where tx_valid && tx_ready; tx_data is frozen until then.
   assign handshake   = tx_valid_q & tx_ready;
   assign len_clamped = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;

`ifdef SEQ_CHECKSUM_EN
   assign last_byte = (idx_q == len_q);
`else
   assign last_byte = (idx_q == (len_q - LEN_W'(1)));
`endif

   sequencer_gap_timer #(
      .CNT_W (CNT_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmr_clr),
      .load_i   (tmr_load),
      .en_i     (tmr_en),
      .value_i  (CNT_W'(GAP_CYCLES)),
      .expire_o (tmr_expire)
   );

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      len_d    = len_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_clr  = 1'b0;
`ifdef SEQ_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               frame_d = frame;
               len_d   = len_clamped;
               idx_d   = '0;
`ifdef SEQ_CHECKSUM_EN
               csum_d  = '0;
               state_d = SEND;
`else
               state_d = (len_clamped == '0) ? DONE : SEND;
`endif
            end
         end
         SEND: begin
            if (handshake) begin
`ifdef SEQ_CHECKSUM_EN
               csum_d = csum_q + tx_data_q;
`endif
               if (last_byte) begin
                  state_d = DONE;
               end else if (GAP_CYCLES == 0) begin
                  idx_d = idx_q + LEN_W'(1);
               end else begin
                  state_d  = GAP;
                  tmr_load = 1'b1;
               end
            end
         end
         GAP: begin
            tmr_en = 1'b1;
            if (tmr_expire) begin
               state_d = SEND;
               idx_d   = idx_q + LEN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Abort beats a same-cycle handshake: the offered byte counts as never sent.
      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         idx_d    = '0;
         tmr_clr  = 1'b1;
         tmr_load = 1'b0;
         tmr_en   = 1'b0;
      end
   end

   // Index mux over the latched frame; the trailer sits at index len when enabled.
   always_comb begin
      byte_sel = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (idx_d == LEN_W'(i)) begin
            byte_sel = frame_d[i*DATA_W +: DATA_W];
         end
      end
`ifdef SEQ_CHECKSUM_EN
      if (idx_d == len_d) begin
         byte_sel = csum_d;
      end
`endif
   end

   always_comb begin
      tx_valid_d = (state_d == SEND);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      tx_data_d  = (state_d == SEND) ? byte_sel : tx_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef SEQ_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench for uart_frame_sequencer with a 4-cycle gap; also builds with SEQ_CHECKSUM_EN.
module tb_uart_frame_sequencer;

   localparam int DATA_W    = 8;
   localparam int MAX_BYTES = 16;
   localparam int GAP       = 4;
   localparam int LEN_W     = 5;
`ifdef SEQ_CHECKSUM_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif

   logic                        clk = 1'b0;
   logic                        rst, start, abort, tx_ready;
   logic [LEN_W-1:0]            len;
   logic [MAX_BYTES*DATA_W-1:0] frame;
   logic [DATA_W-1:0]           tx_data;
   logic                        tx_valid, busy, done;
   logic [1:0]                  dbg_state;

   logic [DATA_W-1:0] exp_q[$];
   int                hs_q[$];
   logic [DATA_W-1:0] bytes_v [MAX_BYTES];
   int checks   = 0;
   int errors   = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cyc      = 0;

   uart_frame_sequencer #(
      .DATA_W     (DATA_W),
      .MAX_BYTES  (MAX_BYTES),
      .GAP_CYCLES (GAP),
      .LEN_W      (LEN_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len         (len),
      .frame       (frame),
      .abort       (abort),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a transfer happens on the coming edge when valid && ready and no abort.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready && !abort) begin
            hs_cnt++;
            hs_q.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h expected no transfer", tx_data);
            end else begin
               check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic logic [MAX_BYTES*DATA_W-1:0] pack_frame();
      logic [MAX_BYTES*DATA_W-1:0] f;
      f = '0;
      for (int i = 0; i < MAX_BYTES; i++) f[i*DATA_W +: DATA_W] = bytes_v[i];
      return f;
   endfunction

   // Driver: queue the first n_push expected bytes (payload then trailer), then pulse start.
   task automatic start_frame(input int n, input int n_push);
      int eff;
      int sum;
      logic [DATA_W-1:0] seq[$];
      eff = (n > MAX_BYTES) ? MAX_BYTES : n;
      sum = 0;
      for (int i = 0; i < eff; i++) begin
         seq.push_back(bytes_v[i]);
         sum += int'(bytes_v[i]);
      end
`ifdef SEQ_CHECKSUM_EN
      seq.push_back(8'(sum));
`endif
      for (int i = 0; i < seq.size() && i < n_push; i++) exp_q.push_back(seq[i]);
      @(posedge clk); #1;
      len   = LEN_W'(n);
      frame = pack_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int idle_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(busy), 32'(0));
      idle_cyc = cyc;
   endtask

   task automatic wait_hs(input string name, input int target);
      int k;
      k = 0;
      @(posedge clk);
      while (hs_cnt < target && k < 100) begin
         @(posedge clk);
         k++;
      end
      check(name, 32'(hs_cnt >= target), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idle_c, base, d0, rel_c, last_hs;
      rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
      len = '0; frame = '0;
      for (int i = 0; i < MAX_BYTES; i++) bytes_v[i] = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_data", 32'(tx_data), 32'(0));
      check("rst_tx_valid", 32'(tx_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(0));
      rst = 1'b0;

      // Six bytes 0x11..0x66, ready held high: acceptances GAP+1 cycles apart
      for (int i = 0; i < 6; i++) bytes_v[i] = 8'((i + 1) * 17);
      hs_q.delete();
      d0 = done_cnt;
      start_frame(6, 99);
      @(negedge clk);
      check("t1_start_busy", 32'(busy), 32'(1));
      check("t1_start_valid", 32'(tx_valid), 32'(1));
      check("t1_first_data", 32'(tx_data), 32'h11);
      wait_idle("t1_idle", idle_c);
      check("t1_hs_count", 32'(hs_q.size()), 32'(6 + TRL));
      for (int i = 1; i < hs_q.size(); i++) check("t1_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'(GAP + 1));
      last_hs = (hs_q.size() > 0) ? hs_q[hs_q.size() - 1] : -1;
      check("t1_done_count", 32'(done_cnt - d0), 32'(1));
      check("t1_done_cycle", 32'(done_cyc), 32'(last_hs));
      check("t1_busy_low_cycle", 32'(idle_c), 32'(done_cyc + 1));
      check("t1_queue_empty", 32'(exp_q.size()), 32'(0));

      // Stall on byte 2 for ten SEND cycles; the gap before it still lasts GAP cycles
      bytes_v[0] = 8'hA1; bytes_v[1] = 8'hB2; bytes_v[2] = 8'hC3; bytes_v[3] = 8'hD4;
      hs_q.delete();
      base = hs_cnt;
      start_frame(4, 99);
      wait_hs("t2_reach_byte2", base + 2);
      #1 tx_ready = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check("t2_stall_valid", 32'(tx_valid), 32'(k >= GAP));
         if (k >= GAP) check("t2_stall_data", 32'(tx_data), 32'hC3);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      rel_c = cyc;
      wait_idle("t2_idle", idle_c);
      check("t2_hs_count", 32'(hs_q.size()), 32'(4 + TRL));
      if (hs_q.size() >= 4) begin
         check("t2_resume_edge", 32'(hs_q[2]), 32'(rel_c + 1));
         check("t2_after_stall_gap", 32'(hs_q[3] - hs_q[2]), 32'(GAP + 1));
      end

      // Abort during the gap after three bytes, then a fresh two-byte frame
      for (int i = 0; i < 5; i++) bytes_v[i] = 8'(i + 1);
      base = hs_cnt;
      d0 = done_cnt;
      start_frame(5, 3);
      wait_hs("t3_reach_byte3", base + 3);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("t3_abort_valid", 32'(tx_valid), 32'(0));
      check("t3_abort_busy", 32'(busy), 32'(0));
      check("t3_abort_state", 32'(dbg_state), 32'(0));
      repeat (8) @(negedge clk);
      check("t3_no_done", 32'(done_cnt - d0), 32'(0));
      check("t3_no_more_bytes", 32'(hs_cnt - base), 32'(3));
      bytes_v[0] = 8'h77; bytes_v[1] = 8'h88;
      start_frame(2, 99);
      wait_idle("t3_restart_idle", idle_c);
      check("t3_restart_queue", 32'(exp_q.size()), 32'(0));

      // Abort arriving together with ready: the byte is not taken
      tx_ready = 1'b0;
      bytes_v[0] = 8'h5A; bytes_v[1] = 8'h5B; bytes_v[2] = 8'h5C;
      base = hs_cnt;
      start_frame(3, 0);
      @(negedge clk);
      check("t4_offer_valid", 32'(tx_valid), 32'(1));
      @(posedge clk); #1;
      abort = 1'b1;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("t4_abort_busy", 32'(busy), 32'(0));
      check("t4_abort_valid", 32'(tx_valid), 32'(0));
      check("t4_no_transfer", 32'(hs_cnt - base), 32'(0));

      // start while busy is ignored
      bytes_v[0] = 8'h31; bytes_v[1] = 8'h32; bytes_v[2] = 8'h33;
      base = hs_cnt;
      d0 = done_cnt;
      start_frame(3, 99);
      wait_hs("t5_first_byte", base + 1);
      #1;
      len   = LEN_W'(2);
      frame = {MAX_BYTES{8'hEE}};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("t5_idle", idle_c);
      check("t5_done_count", 32'(done_cnt - d0), 32'(1));
      check("t5_byte_count", 32'(hs_cnt - base), 32'(3 + TRL));
      check("t5_queue_empty", 32'(exp_q.size()), 32'(0));

      // len == 0
      d0 = done_cnt;
`ifdef SEQ_CHECKSUM_EN
      exp_q.push_back(8'h00);
      start_frame(0, 0);
      wait_idle("t6_idle", idle_c);
      check("t6_queue_empty", 32'(exp_q.size()), 32'(0));
      check("t6_done_count", 32'(done_cnt - d0), 32'(1));
`else
      base = hs_cnt;
      start_frame(0, 0);
      @(negedge clk);
      check("t6_done_pulse", 32'(done), 32'(1));
      check("t6_no_valid", 32'(tx_valid), 32'(0));
      @(negedge clk);
      check("t6_done_single", 32'(done), 32'(0));
      check("t6_busy_low", 32'(busy), 32'(0));
      check("t6_no_bytes", 32'(hs_cnt - base), 32'(0));
`endif

`ifdef SEQ_CHECKSUM_EN
      // Checksum trailer 0xF0 + 0x20 + 0x05 = 0x115 -> 0x15
      bytes_v[0] = 8'hF0; bytes_v[1] = 8'h20; bytes_v[2] = 8'h05;
      start_frame(3, 3);
      exp_q.push_back(8'h15);
      wait_idle("t7_idle", idle_c);
      check("t7_queue_empty", 32'(exp_q.size()), 32'(0));
`endif

      // len above MAX_BYTES is clamped
      for (int i = 0; i < MAX_BYTES; i++) bytes_v[i] = 8'(8'hA0 + i);
      base = hs_cnt;
      start_frame(MAX_BYTES + 3, 99);
      wait_idle("t8_idle", idle_c);
      check("t8_byte_count", 32'(hs_cnt - base), 32'(MAX_BYTES + TRL));
      check("t8_queue_empty", 32'(exp_q.size()), 32'(0));

      // Asynchronous reset mid-SEND, then a normal frame
      tx_ready = 1'b0;
      bytes_v[0] = 8'h42; bytes_v[1] = 8'h43; bytes_v[2] = 8'h44; bytes_v[3] = 8'h45;
      start_frame(4, 0);
      @(negedge clk);
      check("t9_pre_valid", 32'(tx_valid), 32'(1));
      check("t9_pre_data", 32'(tx_data), 32'h42);
      #2 rst = 1'b1;
      #1;
      check("t9_rst_tx_data", 32'(tx_data), 32'(0));
      check("t9_rst_tx_valid", 32'(tx_valid), 32'(0));
      check("t9_rst_busy", 32'(busy), 32'(0));
      check("t9_rst_done", 32'(done), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      tx_ready = 1'b1;
      bytes_v[0] = 8'h9A; bytes_v[1] = 8'hBC;
      base = hs_cnt;
      start_frame(2, 99);
      wait_idle("t9_idle", idle_c);
      check("t9_byte_count", 32'(hs_cnt - base), 32'(2 + TRL));

      check("final_queue_empty", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

Parametrised frame sequencer that latches a multi-byte command frame and feeds it byte by byte to the UART transmitter. It uses a valid/ready handshake and a programmable inter-byte gap. It sits between the command decoder and the UART TX core. It replaces fixed-count, fixed-timing byte queueing with a variable length, backpressure, abort, and an optional checksum trailer.

## Interface
Parameters:
- DATA_W, 8, byte width.
- MAX_BYTES, 16, maximum frame length.
- GAP_CYCLES, 52084, idle clock cycles between a byte's acceptance and presentation of the next byte. 0 is legal.
- LEN_W, $clog2(MAX_BYTES+1), width of len.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; frame and len are sampled on the same edge.
- len  in  LEN_W  number of payload bytes. Values above MAX_BYTES are clamped to MAX_BYTES.
- frame  in  MAX_BYTES*DATA_W  payload; byte 0 is frame[DATA_W-1:0] and is sent first.
- abort  in  1  synchronous cancel of the frame in progress.
- tx_data  out  DATA_W  byte offered to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts tx_data when tx_valid && tx_ready.
- busy  out  1  a frame is in progress (state is not IDLE).
- done  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: on start, latch frame, clamped len, and zero the checksum.
  - len==0 (checksum disabled): go to DONE.
  - Otherwise: go to SEND with index=0.
- SEND: tx_valid=1, tx_data=latched byte[index]. tx_data is held stable until the handshake. On handshake, the byte is added to the checksum.
  - If more bytes remain: go to GAP and load the timer with GAP_CYCLES. With GAP_CYCLES=0, go directly to SEND with index+1.
  - If none remain: go to DONE.
- GAP: tx_valid=0. The timer decrements every cycle. When it reaches 1, go to SEND with index+1.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy is ignored, and the latched frame is not modified.
- abort in any non-IDLE state: go to IDLE on the next edge. tx_valid drops, done is not pulsed, and the index and timer clear. abort wins over a simultaneous handshake. The byte is treated as not sent.
- Arithmetic: index is LEN_W wide and has no wrap-around, since it is bounded by len. Checksum is the sum modulo 2^DATA_W.
- Reset mid-frame: all state returns immediately to IDLE and all outputs go to 0.

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0.
- All outputs are registered.
- start at edge N: busy=1 and tx_valid=1 from cycle N+1.
- Handshake at edge M with a gap: next tx_valid rises at M+GAP_CYCLES+1. With GAP_CYCLES=0, it rises at M+1 (back-to-back).
- Last handshake at edge L: done=1 in cycle L+1, busy=0 from L+2. A new start is accepted in cycle L+2.
- tx_ready low stalls SEND indefinitely with no timeout.
- The gap timer counts only in GAP, never while waiting for ready.

## Configuration
- SEQ_CHECKSUM_EN defined:
  - After the last payload byte, the block sends one trailer byte equal to the sum of all payload bytes modulo 2^DATA_W.
  - The trailer is preceded by a normal gap and uses the same handshake.
  - len==0 sends the trailer only, with value 0.
- SEQ_CHECKSUM_EN undefined: no trailer and no checksum register. len==0 goes directly to DONE.

## Structure
- Package uart_seq_pkg holds:
  - the state enum (IDLE, SEND, GAP, DONE);
  - the default GAP_CYCLES constant (52084);
  - the default byte width.
- Sub-module sequencer_gap_timer: a loadable down-counter with load, value and expire signals. It is instantiated once.
- Byte selection is an index mux over the latched frame register.

## Test plan
- len=6, frame bytes 0x11..0x66, GAP_CYCLES=4, tx_ready=1: 0x11,0x22,…,0x66 accepted with consecutive acceptances 5 cycles apart; done pulses once; busy=0 after.
- tx_ready low for 10 cycles on byte 2: tx_data stays at byte 2 value, tx_valid held, no gap counting; sequence resumes correctly.
- abort asserted during GAP after 3 bytes: tx_valid=0 next cycle, busy=0, no done; a following start with len=2 sends its own 2 bytes from index 0.
- SEQ_CHECKSUM_EN, bytes 0xF0,0x20,0x05: trailer 0x15 sent after 0x05; len=0 sends a single 0x00.
- len=0 without macro: done pulses in cycle 2 after start, tx_valid never rises. len=MAX_BYTES+3 is clamped and sends exactly MAX_BYTES bytes.
- rst asserted asynchronously mid-SEND: all outputs 0 immediately; start after release operates normally. start while busy is ignored.
